decim_avg_iq_core: RTL and testbench

//  I/Q decimator core: the receive-side counterpart of the quadratic interpolator.

---
 rtl/decim_avg_iq_core.sv | 183 ++++++++++++++++++
 tb/tb_decim_avg_iq_core.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_avg_iq_core.sv
// ---------------------------------------------------------------------------
// decim_avg_iq_core
//   I/Q boxcar decimator. It pops I/Q pairs from a show-ahead input FIFO and
//   sums each group of D = 2^k pairs. It then pushes one rounded average per
//   group to the output FIFO. In bypass mode, samples are forwarded one-for-one
//   with pop and push tied together. A job produces olen outputs and ends with
//   a one-cycle done pulse.
//
// Ports
//   clk                rising-edge clock
//   rst                synchronous reset, active-high
//   start              job start, honoured only while idle
//   Empty_i            input FIFO empty (head data valid while low)
//   Afull_i            output FIFO almost full
//   config_reg         word0[0]=bypass, word1[2:0]=k, word3=olen
//   data_from_fifo_I/Q signed sample at the input FIFO head
//   Read_Enable_fifo   pop input FIFO this cycle
//   Write_Enable_fifo  push I_dec/Q_dec this cycle
//   I_dec / Q_dec      signed decimated sample
//   status_reg         [0]done [1]busy [2]stop_empty [3]stop_Afull [4]bypass
// ---------------------------------------------------------------------------
module decim_avg_iq_core #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int DATAPATH_WIDTH = 12,
  parameter int KMAX           = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             Empty_i,
  input  logic                             Afull_i,
  input  logic [4*CONFIG_WIDTH-1:0]        config_reg,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_fifo_I,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_fifo_Q,
  output logic                             Read_Enable_fifo,
  output logic                             Write_Enable_fifo,
  output logic signed [DATAPATH_WIDTH-1:0] I_dec,
  output logic signed [DATAPATH_WIDTH-1:0] Q_dec,
  output logic [7:0]                       status_reg
);

  localparam int DW = DATAPATH_WIDTH;
  // One spare bit above DW+KMAX so the rounding bias can never wrap the sum.
  localparam int AW = DATAPATH_WIDTH + KMAX + 1;
  localparam logic [2:0] KMAX_L = 3'(KMAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              r_state;
  logic                    r_byp;
  logic [2:0]              r_k;
  logic [CONFIG_WIDTH-1:0] r_olen;
  logic [CONFIG_WIDTH-1:0] r_out_cnt;
  logic [KMAX:0]           r_cnt;
  logic signed [AW-1:0]    r_acc_i_p0;
  logic signed [AW-1:0]    r_acc_q_p0;
  logic signed [DW-1:0]    r_i_dec_p1;
  logic signed [DW-1:0]    r_q_dec_p1;

  logic                    w_busy;
  logic                    w_pop_n;
  logic                    w_push_n;
  logic                    w_xfer_b;
  logic                    w_byp_act;
  logic                    w_stop_empty;
  logic                    w_stop_afull;
  logic [2:0]              w_k_cfg;
  logic [CONFIG_WIDTH-1:0] w_olen_cfg;
  logic [CONFIG_WIDTH-1:0] w_out_next;
  logic                    w_olen_hit;
  logic [KMAX:0]           w_d_m1;
  logic                    w_cnt_last;
  logic signed [AW-1:0]    w_sum_i;
  logic signed [AW-1:0]    w_sum_q;
  logic                    w_unused_cfg;

  // Round half up: add 2^(k-1) before the arithmetic shift. For a boxcar
  // average, the result is always inside the input range, so no clamp is needed.
  function automatic logic signed [DW-1:0] round_shift(
    input logic signed [AW-1:0] sum,
    input logic [2:0]           k
  );
    logic signed [AW-1:0] bias;
    logic signed [AW-1:0] shifted;
    bias    = (k == 3'd0) ? '0 : (AW'(1) << (k - 3'd1));
    shifted = (sum + bias) >>> k;
    return shifted[DW-1:0];
  endfunction

  assign w_k_cfg      = config_reg[CONFIG_WIDTH +: 3];
  assign w_olen_cfg   = config_reg[3*CONFIG_WIDTH +: CONFIG_WIDTH];
  assign w_unused_cfg = ^{config_reg[3*CONFIG_WIDTH-1:CONFIG_WIDTH+3],
                          config_reg[CONFIG_WIDTH-1:1]};

  assign w_out_next = r_out_cnt + CONFIG_WIDTH'(1);
  assign w_olen_hit = (w_out_next == r_olen);
  assign w_d_m1     = ((KMAX+1)'(1) << r_k) - (KMAX+1)'(1);
  assign w_cnt_last = (r_cnt == w_d_m1);

  assign w_sum_i = r_acc_i_p0 + {{(AW-DW){data_from_fifo_I[DW-1]}}, data_from_fifo_I};
  assign w_sum_q = r_acc_q_p0 + {{(AW-DW){data_from_fifo_Q[DW-1]}}, data_from_fifo_Q};

  // Strobes are gated by rst so an aborted job stops popping/pushing at once.
  assign w_busy    = (r_state != S_IDLE);
  assign w_pop_n   = ~rst & (r_state == S_ACC) & ~r_byp & ~Empty_i;
  assign w_push_n  = ~rst & (r_state == S_OUT) & ~Afull_i;
  assign w_xfer_b  = ~rst & (r_state == S_ACC) & r_byp & ~Empty_i & ~Afull_i;
  assign w_byp_act = r_byp & w_busy;

  assign Read_Enable_fifo  = w_pop_n | w_xfer_b;
  assign Write_Enable_fifo = w_push_n | w_xfer_b;
  assign I_dec = w_byp_act ? data_from_fifo_I : r_i_dec_p1;
  assign Q_dec = w_byp_act ? data_from_fifo_Q : r_q_dec_p1;

  assign w_stop_empty = (r_state == S_ACC) & Empty_i;
  assign w_stop_afull = ((r_state == S_OUT) | ((r_state == S_ACC) & r_byp)) & Afull_i;
  assign status_reg   = {3'b000, r_byp, w_stop_afull, w_stop_empty, w_busy,
                         (r_state == S_DONE)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byp      <= 1'b0;
      r_k        <= '0;
      r_olen     <= '0;
      r_out_cnt  <= '0;
      r_cnt      <= '0;
      r_acc_i_p0 <= '0;
      r_acc_q_p0 <= '0;
      r_i_dec_p1 <= '0;
      r_q_dec_p1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_byp      <= config_reg[0];
            r_k        <= (w_k_cfg > KMAX_L) ? KMAX_L : w_k_cfg;
            r_olen     <= w_olen_cfg;
            r_out_cnt  <= '0;
            r_cnt      <= '0;
            r_acc_i_p0 <= '0;
            r_acc_q_p0 <= '0;
            r_state    <= (w_olen_cfg == '0) ? S_DONE : S_ACC;
          end
        end
        // p0: accumulate popped samples; the group's last pop also registers
        // the rounded average so it is ready for the push on the next cycle.
        S_ACC: begin
          if (r_byp) begin
            if (~Empty_i & ~Afull_i) begin
              r_out_cnt <= w_out_next;
              if (w_olen_hit) r_state <= S_DONE;
            end
          end else if (~Empty_i) begin
            r_acc_i_p0 <= w_sum_i;
            r_acc_q_p0 <= w_sum_q;
            r_cnt      <= r_cnt + (KMAX+1)'(1);
            if (w_cnt_last) begin
              r_i_dec_p1 <= round_shift(w_sum_i, r_k);
              r_q_dec_p1 <= round_shift(w_sum_q, r_k);
              r_state    <= S_OUT;
            end
          end
        end
        // p1: hold the average until the output FIFO accepts it.
        S_OUT: begin
          if (~Afull_i) begin
            r_out_cnt  <= w_out_next;
            r_cnt      <= '0;
            r_acc_i_p0 <= '0;
            r_acc_q_p0 <= '0;
            r_state    <= w_olen_hit ? S_DONE : S_ACC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decim_avg_iq_core.sv
module tb_decim_avg_iq_core;
  localparam int CW   = 32;
  localparam int DW   = 12;
  localparam int KMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, Empty_i, Afull_i;
  logic [4*CW-1:0]      config_reg;
  logic signed [DW-1:0] din_i, din_q;
  logic                 re, we;
  logic signed [DW-1:0] i_dec, q_dec;
  logic [7:0]           status;

  decim_avg_iq_core #(.CONFIG_WIDTH(CW), .DATAPATH_WIDTH(DW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .Empty_i(Empty_i), .Afull_i(Afull_i),
    .config_reg(config_reg), .data_from_fifo_I(din_i), .data_from_fifo_Q(din_q),
    .Read_Enable_fifo(re), .Write_Enable_fifo(we), .I_dec(i_dec), .Q_dec(q_dec),
    .status_reg(status)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: input FIFO contents and expected decimator outputs.
  int in_i[$], in_q[$];
  int exp_i[$], exp_q[$];
  bit byp_m;
  int d_m, olen_m;
  int pops, pushes;
  int phase;      // 0 idle, 1 start cycle, 2 running, 3 done cycle, 4 back to idle
  bit pending;    // a completed group is waiting to be pushed
  bit popped;
  bit scramble;
  int e_after, e_len, e_rem;
  int a_group, a_len, a_rem;
  int rand_pct;
  int poke_pop;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  // Average of d samples rounded half up: floor(sum/d + 1/2).
  function automatic int round_ref(input int s, input int d);
    return fdiv(2 * s + d, 2 * d);
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic add_sample(input int si, input int sq);
    in_i.push_back(si);
    in_q.push_back(sq);
  endtask

  task automatic drive();
    bit e_rnd, a_rnd;
    e_rnd = (rand_pct > 0) && (int'($urandom_range(0, 99)) < rand_pct);
    a_rnd = (rand_pct > 0) && (int'($urandom_range(0, 99)) < rand_pct);
    Empty_i = (in_i.size() == 0) || (e_rem > 0) || e_rnd;
    Afull_i = (a_rem > 0) || a_rnd;
    if (in_i.size() > 0) begin
      din_i = DW'(in_i[0]);
      din_q = DW'(in_q[0]);
    end else begin
      din_i = DW'($urandom);
      din_q = DW'($urandom);
    end
  endtask

  task automatic cycle();
    bit xfer;
    popped = 1'b0;
    @(negedge clk);
    case (phase)
      0: begin
        check_val("idle_re", re, 0);
        check_val("idle_we", we, 0);
      end
      1: begin
        check_val("start_busy", status[1], 0);
        check_val("start_re", re, 0);
        phase = (olen_m == 0) ? 3 : 2;
      end
      2: begin
        if (byp_m) begin
          xfer = !Empty_i && !Afull_i;
          check_val("byp_re", re, xfer);
          check_val("byp_we", we, xfer);
          check_val("byp_stop_empty", status[2], Empty_i);
          check_val("byp_stop_afull", status[3], Afull_i);
          check_val("byp_flag", status[4], 1);
          if (xfer && re) begin
            check_val("byp_i", i_dec, in_i[0]);
            check_val("byp_q", q_dec, in_q[0]);
            pops++;
            pushes++;
            popped = 1'b1;
            if (pushes == olen_m) phase = 3;
          end
        end else if (pending) begin
          check_val("out_re", re, 0);
          if (Afull_i) begin
            check_val("out_we_held", we, 0);
            check_val("stop_afull", status[3], 1);
          end else begin
            check_val("out_we", we, 1);
            if (exp_i.size() > 0) begin
              check_val("dec_i", i_dec, exp_i[0]);
              check_val("dec_q", q_dec, exp_q[0]);
              void'(exp_i.pop_front());
              void'(exp_q.pop_front());
            end else begin
              check_val("extra_push", exp_i.size(), 1);
            end
            pushes++;
            pending = 1'b0;
            if (pushes == olen_m) phase = 3;
          end
        end else begin
          check_val("acc_re", re, !Empty_i);
          check_val("acc_we", we, 0);
          check_val("stop_empty", status[2], Empty_i);
          check_val("acc_busy", status[1], 1);
          if (re && !Empty_i) begin
            pops++;
            popped = 1'b1;
            if (pops % d_m == 0) pending = 1'b1;
          end
        end
      end
      3: begin
        check_val("done_pulse", status[1:0], 3);
        check_val("done_re", re, 0);
        check_val("done_we", we, 0);
        phase = 4;
      end
      default: begin
        check_val("back_idle", status[1:0], 0);
        phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    if (popped) begin
      void'(in_i.pop_front());
      void'(in_q.pop_front());
    end
    start = 1'b0;
    if (scramble) begin
      config_reg = {$urandom, $urandom, $urandom, $urandom};
      scramble   = 1'b0;
    end
    if (popped && pops == poke_pop) begin
      start      = 1'b1;
      config_reg = {$urandom, $urandom, $urandom, $urandom};
    end
    if (e_rem > 0) e_rem--;
    if (popped && pops == e_after) e_rem = e_len;
    if (a_rem > 0) a_rem--;
    if (popped && pending && (pops / d_m) == a_group) a_rem = a_len;
    drive();
  endtask

  // Caller has loaded in_i/in_q; abort_at >= 0 resets the DUT after that many pops.
  task automatic run_job(input bit byp, input int kcfg, input int olen, input int abort_at);
    int k_eff, s_i, s_q, n;
    k_eff  = (kcfg > KMAX) ? KMAX : kcfg;
    d_m    = 1 << k_eff;
    byp_m  = byp;
    olen_m = olen;
    exp_i.delete();
    exp_q.delete();
    if (!byp) begin
      for (int g = 0; g < olen; g++) begin
        s_i = 0;
        s_q = 0;
        for (int j = 0; j < d_m; j++) begin
          s_i += in_i[g * d_m + j];
          s_q += in_q[g * d_m + j];
        end
        exp_i.push_back(round_ref(s_i, d_m));
        exp_q.push_back(round_ref(s_q, d_m));
      end
    end
    pops     = 0;
    pushes   = 0;
    pending  = 1'b0;
    e_rem    = 0;
    a_rem    = 0;
    phase    = 1;
    scramble = 1'b1;
    config_reg            = '0;
    config_reg[0]         = byp;
    config_reg[CW +: 3]   = 3'(kcfg);
    config_reg[3*CW +: CW] = CW'(olen);
    start = 1'b1;
    drive();
    n = 0;
    while (phase != 0 && n < 3000) begin
      cycle();
      n++;
      if (abort_at >= 0 && pops == abort_at) break;
    end
    if (abort_at < 0) begin
      check_val("job_end", phase, 0);
      check_val("job_pops", pops, byp ? olen : olen * d_m);
      check_val("job_pushes", pushes, olen);
      in_i.delete();
      in_q.delete();
    end
    phase    = 0;
    e_after  = -1;
    a_group  = -1;
    poke_pop = -1;
    e_rem    = 0;
    a_rem    = 0;
    drive();
  endtask

  task automatic load_ramp();
    for (int v = 1; v <= 8; v++) add_sample(v, -v);
    add_sample(100, 100);
    add_sample(-100, -100);
  endtask

  initial begin
    int kc, ol, nsamp;
    bit bp;
    rst        = 1'b1;
    start      = 1'b0;
    config_reg = '0;
    Empty_i    = 1'b1;
    Afull_i    = 1'b0;
    din_i      = '0;
    din_q      = '0;
    rand_pct   = 0;
    e_after    = -1;
    a_group    = -1;
    poke_pop   = -1;
    e_rem      = 0;
    a_rem      = 0;
    phase      = 0;
    scramble   = 1'b0;
    d_m        = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_status", status, 0);
    check_val("rst_re", re, 0);
    check_val("rst_we", we, 0);
    check_val("rst_i", i_dec, 0);
    check_val("rst_q", q_dec, 0);
    @(posedge clk);
    #1;

    // T1 ramp, k=2, two outputs
    load_ramp();
    run_job(1'b0, 2, 2, -1);

    // T2 rounding and extremes
    add_sample(1, -1);  add_sample(2, -2);  add_sample(2, -2);  add_sample(2, -2);
    for (int j = 0; j < 4; j++) add_sample(2047, -2048);
    run_job(1'b0, 2, 2, -1);

    // T3 input empty stall mid-group
    load_ramp();
    e_after = 1;
    e_len   = 5;
    run_job(1'b0, 2, 2, -1);

    // T4 output almost-full on entering OUT
    load_ramp();
    a_group = 1;
    a_len   = 3;
    run_job(1'b0, 2, 2, -1);

    // T5 empty job, and a start pulse plus config change while busy
    add_sample(5, 5);
    run_job(1'b0, 2, 0, -1);
    load_ramp();
    poke_pop = 3;
    run_job(1'b0, 2, 2, -1);

    // k=0 pass-through and k clamped to KMAX
    for (int j = 0; j < 5; j++) add_sample(rnd_sample(), rnd_sample());
    run_job(1'b0, 0, 3, -1);
    for (int j = 0; j < 18; j++) add_sample(rnd_sample(), rnd_sample());
    run_job(1'b0, 7, 1, -1);

    // T6 bypass
    for (int j = 0; j < 5; j++) add_sample(rnd_sample(), rnd_sample());
    run_job(1'b1, 2, 3, -1);

    // Randomized jobs with random FIFO stalls
    rand_pct = 25;
    for (int r = 0; r < 10; r++) begin
      bp = (r % 4 == 3);
      kc = int'($urandom_range(0, 7));
      ol = int'($urandom_range(1, 3));
      nsamp = bp ? ol : ol * (1 << ((kc > KMAX) ? KMAX : kc));
      for (int j = 0; j < nsamp + 2; j++) add_sample(rnd_sample(), rnd_sample());
      run_job(bp, kc, ol, -1);
    end
    rand_pct = 0;
    drive();

    // Reset mid-job after one output has been pushed
    load_ramp();
    run_job(1'b0, 2, 2, 6);
    Empty_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_re", re, 0);
    check_val("abort_we", we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_status", status, 0);
    check_val("abort_re_after", re, 0);
    check_val("abort_we_after", we, 0);
    check_val("abort_i", i_dec, 0);
    check_val("abort_q", q_dec, 0);
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) cycle();
    in_i.delete();
    in_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
